// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the serial adder: FSM state encodings and slice width.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned SLICE_W = 2;

endpackage

// File: rtl/serial_add_ctrl_add2_slice.sv
// 2-bit ripple-carry adder slice made of two full-adder cells.
module add2_slice
  import serial_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic c1;

  // Bit 0 full adder
  assign s[0] = a[0] ^ b[0] ^ cin;
  assign c1   = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));

  // Bit 1 full adder
  assign s[1] = a[1] ^ b[1] ^ c1;
  assign cout = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-cycle WIDTH-bit adder: one 2-bit slice reused for WIDTH/2 cycles,
// with start/busy/done handshake and held result registers.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned STEPS = WIDTH / SLICE_W;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  state_t             state;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_next;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;

  add2_slice u_slice (
    .a    (op_a[SLICE_W-1:0]),
    .b    (op_b[SLICE_W-1:0]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // New slice result enters at the top; the accumulator fills LSB-first.
  assign acc_next = {slice_s, acc[WIDTH-1:SLICE_W]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc   <= acc_next;
          op_a  <= op_a >> SLICE_W;
          op_b  <= op_b >> SLICE_W;
          carry <= slice_cout;
          // Final step commits the result; the counter stops at LAST.
          if (cnt == LAST) begin
            sum   <= acc_next;
            cout  <= slice_cout;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) against an arithmetic model.
module tb_serial_add_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int LAT = WIDTH / 2 + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int pass_cnt = 0;
  int total = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic c);
    return (WIDTH+1)'(x) + (WIDTH+1)'(y) + (WIDTH+1)'(c);
  endfunction

  // Issues one start pulse (called at a falling edge) and watches the operation.
  task automatic do_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ic,
                       output int lat, output int busy_cnt,
                       output logic [WIDTH-1:0] s, output logic co);
    lat = -1;
    busy_cnt = 0;
    s = 'x;
    co = 1'bx;
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (busy) busy_cnt++;
      if (done && lat < 0) begin lat = i; s = sum; co = cout; end
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string name, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic ic, input logic check_busy);
    int lat, bc;
    logic [WIDTH-1:0] s;
    logic co;
    logic [WIDTH:0] exp;
    exp = ref_add(ia, ib, ic);
    do_op(ia, ib, ic, lat, bc, s, co);
    total++;
    if ({co, s} !== exp) $display("FAIL %s result: got %h, required %h", name, {co, s}, exp);
    else pass_cnt++;
    total++;
    if (lat !== LAT) $display("FAIL %s latency: got %0d, required %0d", name, lat, LAT);
    else pass_cnt++;
    if (check_busy) begin
      total++;
      if (bc !== LAT) $display("FAIL %s busy_cycles: got %0d, required %0d", name, bc, LAT);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, cout, sum} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, required all zero",
               busy, done, cout, sum);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    check_op("vec_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0);
    check_op("vec_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    check_op("vec_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 1'b1);
    total++;
    if (sum !== 8'hFF || cout !== 1'b1)
      $display("FAIL result_hold: got %b_%h, required 1_ff", cout, sum);
    else pass_cnt++;
  endtask

  task automatic test_start_held();
    int done_idx[$];
    logic [WIDTH-1:0] done_sum[$];
    logic [WIDTH:0] exp1, exp2;
    exp1 = ref_add(8'h01, 8'h02, 1'b0);
    exp2 = ref_add(8'h05, 8'h06, 1'b0);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 2) begin a = 8'h05; b = 8'h06; end
      if (i == 10) start = 1'b0;
      if (done) begin done_idx.push_back(i); done_sum.push_back(sum); end
    end
    total++;
    if (done_idx.size() !== 2) $display("FAIL held_done_count: got %0d, required 2", done_idx.size());
    else pass_cnt++;
    if (done_idx.size() == 2) begin
      total++;
      if (done_sum[0] !== exp1[WIDTH-1:0])
        $display("FAIL held_first_sum: got %h, required %h", done_sum[0], exp1[WIDTH-1:0]);
      else pass_cnt++;
      total++;
      if (done_sum[1] !== exp2[WIDTH-1:0])
        $display("FAIL held_second_sum: got %h, required %h", done_sum[1], exp2[WIDTH-1:0]);
      else pass_cnt++;
      total++;
      if (done_idx[1] - done_idx[0] !== LAT + 1)
        $display("FAIL held_spacing: got %0d, required %0d", done_idx[1] - done_idx[0], LAT + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_operand_change();
    int lat;
    logic [WIDTH-1:0] s;
    logic co;
    lat = -1;
    s = 'x;
    co = 1'bx;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      if (done && lat < 0) begin lat = i; s = sum; co = cout; end
      if (!busy) break;
      @(negedge clk);
    end
    total++;
    if ({co, s} !== ref_add(8'h10, 8'h20, 1'b0) || lat !== LAT)
      $display("FAIL operand_change: got %b_%h lat=%0d, required 0_30 lat=%0d", co, s, lat, LAT);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    a = 8'hC3; b = 8'h7E; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({busy, done, cout, sum} !== '0)
      $display("FAIL reset_abort: got busy=%b done=%b cout=%b sum=%h, required all zero",
               busy, done, cout, sum);
    else pass_cnt++;
    repeat (6) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0)
        $display("FAIL reset_abort_idle: got busy=%b done=%b, required 0 0", busy, done);
      else pass_cnt++;
    end
    check_op("after_abort", 8'hC3, 8'h7E, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      check_op("random", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_start_held();
    test_operand_change();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
